// File: rtl/bin_streamer.sv
// Streams one frame of frequency-bin magnitudes from a BRAM to a byte transmitter:
// a header byte, then every bin in order, while tracking the peak bin of the frame.
module bin_streamer #(
  parameter int unsigned       addr_w = 7,
  parameter int unsigned       data_w = 8,
  parameter logic [data_w-1:0] header = data_w'(8'hAA)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              r_en,
  output logic [addr_w-1:0] r_addr,
  input  logic [data_w-1:0] d_in,
  output logic [data_w-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [addr_w-1:0] peak_bin,
  output logic [data_w-1:0] peak_val
);

  localparam logic [addr_w-1:0] LAST_BIN = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    READ   = 3'd2,
    LATCH  = 3'd3,
    SEND   = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [addr_w-1:0]   cnt_q, cnt_d;
  logic                r_en_q, r_en_d;
  logic [addr_w-1:0]   r_addr_q, r_addr_d;
  logic [data_w-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [addr_w-1:0]   peak_bin_q, peak_bin_d;
  logic [data_w-1:0]   peak_val_q, peak_val_d;
  logic [addr_w-1:0]   run_bin_q, run_bin_d;
  logic [data_w-1:0]   run_val_q, run_val_d;

  // Registered outputs are computed one cycle ahead from the state transition.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_en_d     = 1'b0;
    r_addr_d   = r_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    peak_bin_d = peak_bin_q;
    peak_val_d = peak_val_q;
    run_bin_d  = run_bin_q;
    run_val_d  = run_val_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HEADER;
          cnt_d      = '0;
          run_bin_d  = '0;
          run_val_d  = '0;
          busy_d     = 1'b1;
          tx_data_d  = header;
          tx_valid_d = 1'b1;
        end
      end
      HEADER: begin
        if (tx_valid_q && tx_ready) begin
          state_d    = READ;
          tx_valid_d = 1'b0;
          r_en_d     = 1'b1;
          r_addr_d   = cnt_q;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        state_d    = SEND;
        tx_data_d  = d_in;
        tx_valid_d = 1'b1;
        // Strict compare so ties keep the lower bin index.
        if (d_in > run_val_q) begin
          run_bin_d = cnt_q;
          run_val_d = d_in;
        end
      end
      SEND: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (cnt_q == LAST_BIN) begin
            state_d    = DONE;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            peak_bin_d = run_bin_q;
            peak_val_d = run_val_q;
          end else begin
            state_d  = READ;
            cnt_d    = cnt_q + addr_w'(1);
            r_en_d   = 1'b1;
            r_addr_d = cnt_q + addr_w'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      r_en_q     <= 1'b0;
      r_addr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      peak_bin_q <= '0;
      peak_val_q <= '0;
      run_bin_q  <= '0;
      run_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_en_q     <= r_en_d;
      r_addr_q   <= r_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      peak_bin_q <= peak_bin_d;
      peak_val_q <= peak_val_d;
      run_bin_q  <= run_bin_d;
      run_val_q  <= run_val_d;
    end
  end

  assign r_en     = r_en_q;
  assign r_addr   = r_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign peak_bin = peak_bin_q;
  assign peak_val = peak_val_q;

endmodule

// File: tb/tb_bin_streamer.sv
// Directed bench for bin_streamer: BRAM model, byte/read monitors and frame-level checks.
module tb_bin_streamer;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NBINS  = 1 << ADDR_W;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] peak_bin;
  logic [DATA_W-1:0] peak_val;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mem [NBINS];
  logic [DATA_W-1:0] bytes_q [$];
  int  rd_cnt;
  int  done_cnt;
  bit  rnd_ready;
  bit  hold;
  logic [DATA_W-1:0] hold_data;
  logic prev_ren;

  bin_streamer #(.addr_w(ADDR_W), .data_w(DATA_W), .header(8'hAA)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .r_en(r_en), .r_addr(r_addr),
    .d_in(d_in), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .peak_bin(peak_bin), .peak_val(peak_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency BRAM read port.
  always @(posedge clk) if (r_en) d_in <= mem[r_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitors sample at the falling edge, between active edges.
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold) begin
        check("tx_valid_stable", 32'(tx_valid), 32'd1);
        check("tx_data_stable", 32'(tx_data), 32'(hold_data));
      end
      hold      = tx_valid && !tx_ready;
      hold_data = tx_data;
      if (tx_valid && tx_ready) bytes_q.push_back(tx_data);
      if (r_en) begin
        check("r_addr", 32'(r_addr), 32'(rd_cnt));
        check("r_en_one_cycle", 32'(prev_ren), 32'd0);
        rd_cnt++;
      end
      prev_ren = r_en;
      if (done) done_cnt++;
    end else begin
      hold     = 1'b0;
      prev_ren = 1'b0;
    end
  end

  task automatic fill_ramp();
    for (int i = 0; i < NBINS; i++) mem[i] = 8'(i);
  endtask

  task automatic begin_frame();
    bytes_q.delete();
    rd_cnt   = 0;
    done_cnt = 0;
    @(negedge clk); #1; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
  endtask

  // Runs a full frame; restart_at >= 0 pulses start again once that many bytes have gone out.
  task automatic run_frame(input int restart_at, input int prev_pb,
                           input int exp_pb, input int exp_pv);
    bit restarted = 1'b0;
    bit seen_done = 1'b0;
    begin_frame();
    for (int n = 0; n < 5000 && !seen_done; n++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        check("busy_in_done", 32'(busy), 32'd0);
        check("peak_bin", 32'(peak_bin), 32'(exp_pb));
        check("peak_val", 32'(peak_val), 32'(exp_pv));
      end else begin
        check("busy_in_frame", 32'(busy), 32'd1);
        if (restart_at >= 0 && !restarted && bytes_q.size() >= restart_at) begin
          restarted = 1'b1;
          check("peak_hold", 32'(peak_bin), 32'(prev_pb));
          start = 1'b1;
        end
      end
    end
    check("done_seen", 32'(seen_done), 32'd1);
    repeat (6) @(negedge clk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("byte_count", 32'(bytes_q.size()), 32'(NBINS + 1));
    check("read_count", 32'(rd_cnt), 32'(NBINS));
    check("busy_after", 32'(busy), 32'd0);
    if (bytes_q.size() == NBINS + 1) begin
      check("byte_header", 32'(bytes_q[0]), 32'hAA);
      for (int i = 0; i < NBINS; i++) check("byte_bin", 32'(bytes_q[i+1]), 32'(mem[i]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_r_en"}, 32'(r_en), 32'd0);
    check({tag, "_r_addr"}, 32'(r_addr), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_peak_bin"}, 32'(peak_bin), 32'd0);
    check({tag, "_peak_val"}, 32'(peak_val), 32'd0);
  endtask

  initial begin
    bit reached;
    reset_n   = 1'b0;
    start     = 1'b0;
    rnd_ready = 1'b0;
    hold      = 1'b0;
    prev_ren  = 1'b0;
    fill_ramp();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp data, transmitter always ready.
    run_frame(-1, 0, 127, 127);

    // Same data with a stalling transmitter.
    rnd_ready = 1'b1;
    run_frame(-1, 127, 127, 127);
    rnd_ready = 1'b0;

    // Two equal maxima: the lower index must win.
    for (int i = 0; i < NBINS; i++) mem[i] = 8'h10;
    mem[5] = 8'hF0;
    mem[9] = 8'hF0;
    run_frame(-1, 127, 5, 8'hF0);

    // Extra start mid-frame is ignored; peak of previous frame still held.
    fill_ramp();
    run_frame(40, 5, 127, 127);

    // Reset while bin 60 is being offered.
    begin_frame();
    reached = 1'b0;
    for (int n = 0; n < 2000 && !reached; n++) begin
      @(negedge clk); #1;
      if (bytes_q.size() >= 62 && tx_valid) reached = 1'b1;
    end
    check("reset_point_reached", 32'(reached), 32'd1);
    check("reset_point_data", 32'(tx_data), 32'd60);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (4) @(negedge clk);
    #1;
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    check("midreset_reads", 32'(rd_cnt), 32'd61);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(-1, 0, 127, 127);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_streamer.md
BIN_STREAMER -- requirements
Module: bin_streamer

Interface
REQ-001 The block SHALL have parameter addr_w, default 7, as the frequency-bin address width; bins per frame = 2**addr_w.
REQ-002 The block SHALL have parameter data_w, default 8, as the bin magnitude width and the tx_data width.
REQ-003 The block SHALL have parameter header, default 8'hAA (data_w bits), as the frame-start byte.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to stream one frame.
REQ-007 r_en  output  1  read enable to freq_bram read port.
REQ-008 r_addr  output  addr_w  read address to freq_bram.
REQ-009 d_in  input  data_w  freq_bram d_out, valid on the second rising edge after the cycle r_en=1.
REQ-010 tx_data  output  data_w  byte to the serial transmitter.
REQ-011 tx_valid  output  1  tx_data valid.
REQ-012 tx_ready  input  1  transmitter accepts tx_data.
REQ-013 busy  output  1  frame in progress.
REQ-014 done  output  1  one-cycle pulse at frame end.
REQ-015 peak_bin  output  addr_w  index of largest bin of last completed frame.
REQ-016 peak_val  output  data_w  value of that bin.

Function
REQ-017 The FSM SHALL have states IDLE, HEADER, READ, LATCH, SEND, DONE.
REQ-018 IDLE: start=1 -> HEADER; bin counter := 0; running peak := bin 0 / value 0; busy=1 from the next cycle.
REQ-019 HEADER: tx_data=header, tx_valid=1; on tx_valid&tx_ready edge -> READ.
REQ-020 READ: r_en=1, r_addr=bin counter for exactly one cycle -> LATCH.
REQ-021 LATCH: r_en=0; at the end of this cycle the block SHALL capture d_in into the tx_data register -> SEND.
REQ-022 SEND: tx_valid=1, tx_data stable until the handshake edge; on handshake, last bin (counter = 2**addr_w-1) -> DONE, else counter+1 -> READ.
REQ-023 Transfer SHALL occur only on a rising edge with tx_valid=1 and tx_ready=1; tx_data and tx_valid SHALL NOT change while tx_valid=1 and tx_ready=0.
REQ-024 Peak tracking: at each LATCH capture, if d_in > running peak (unsigned, strict), running peak := {counter, d_in}; ties keep the lower bin index.
REQ-025 DONE: done=1 for one cycle; peak_bin/peak_val := running peak; busy=0 -> IDLE.
REQ-026 peak_bin/peak_val SHALL hold between frames and change only in DONE.
REQ-027 start while busy=1 or in DONE SHALL be ignored (not queued).
REQ-028 The bin counter SHALL be addr_w bits; the last-bin test SHALL use the counter value, not overflow; counter wraps to 0 only at frame start.
REQ-029 r_en SHALL be 0 in every state except READ; r_addr SHALL hold its last value outside READ.
REQ-030 Frame length SHALL be exactly 1 + 2**addr_w tx handshakes; minimum frame latency start->done with tx_ready tied 1 = 3 + 3*2**addr_w cycles.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE and set r_en, r_addr, tx_data, tx_valid, busy, done, peak_bin, peak_val, counter to 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no done pulse; the next start after reset_n=1 SHALL begin a fresh frame at HEADER.

Verification
REQ-033 BRAM preloaded bin i = i, tx_ready=1, pulse start -> bytes AA,00,01,...,7F; done once; peak_bin=127, peak_val=127.
REQ-034 tx_ready toggled pseudo-randomly -> identical byte sequence, tx_data stable while tx_valid&!tx_ready, no byte dropped or duplicated.
REQ-035 Bins all 0x10 except bins 5 and 9 = 0xF0 -> peak_bin=5, peak_val=0xF0 (tie keeps lower index).
REQ-036 start pulsed again at byte 40 of a frame -> ignored; exactly 129 bytes, one done pulse.
REQ-037 reset_n low during SEND of bin 60 -> all outputs 0 immediately, no done; new start -> full frame beginning AA,00.
REQ-038 Check r_en high exactly one cycle per bin, r_addr = bin index in that cycle, 128 reads per frame.
